// File: rtl/uc_arbiter.sv
// rtl/uc_arbiter.sv - unit clause arbiter: per-engine slots, round-robin grant,
// duplicate/conflict filtering against a short literal history, push into ucq.
module uc_arbiter #(
    parameter int NUM_ENG    = 4,
    parameter int UC_LENGTH  = 512,
    parameter int HIST_DEPTH = 8,
    parameter int CNT_W      = 16,
    localparam int LIT_W     = $clog2(UC_LENGTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_ENG-1:0]              eng2uca_valid,
    input  logic [NUM_ENG-1:0][LIT_W-1:0]   eng2uca_lit,
    output logic [NUM_ENG-1:0]              uca2eng_ready,
    input  logic                            ucq_full,
    output logic                            push,
    output logic [LIT_W-1:0]                uca2ucq,
    output logic                            conflict,
    output logic [CNT_W-1:0]                drop_cnt
);
    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    logic [NUM_ENG-1:0]                slot_valid_q, slot_valid_d;
    logic [NUM_ENG-1:0][LIT_W-1:0]     slot_lit_q, slot_lit_d;
    logic [HIST_DEPTH-1:0]             hist_valid_q, hist_valid_d;
    logic [HIST_DEPTH-1:0][LIT_W-1:0]  hist_lit_q, hist_lit_d;
    logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic                              conflict_q, conflict_d;
    logic [CNT_W-1:0]                  drop_cnt_q, drop_cnt_d;

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] cand_idx;
    logic             cand_found;
    logic [LIT_W-1:0] cand_lit;
    logic             grant;
    logic             hit_same;
    logic             hit_opp;

    // Walk from the farthest position back to rr_ptr so the nearest valid slot wins.
    always_comb begin
        idx        = '0;
        cand_idx   = '0;
        cand_found = 1'b0;
        for (int k = NUM_ENG - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_ENG);
            if (slot_valid_q[idx]) begin
                cand_found = 1'b1;
                cand_idx   = idx;
            end
        end
    end

    assign cand_lit = slot_lit_q[cand_idx];
    assign grant    = cand_found && !ucq_full && !conflict_q && !flush && !rst;

    always_comb begin
        hit_same = 1'b0;
        hit_opp  = 1'b0;
        for (int h = 0; h < HIST_DEPTH; h++) begin
            if (hist_valid_q[h] && (hist_lit_q[h] == cand_lit)) begin
                hit_same = 1'b1;
            end
            if (hist_valid_q[h] && (hist_lit_q[h] == {cand_lit[LIT_W-1:1], ~cand_lit[0]})) begin
                hit_opp = 1'b1;
            end
        end
    end

    assign push          = grant && !hit_same && !hit_opp;
    assign uca2ucq       = cand_found ? cand_lit : '0;
    assign uca2eng_ready = ~slot_valid_q;
    assign conflict      = conflict_q;
    assign drop_cnt      = drop_cnt_q;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_lit_d   = slot_lit_q;
        hist_valid_d = hist_valid_q;
        hist_lit_d   = hist_lit_q;
        rr_ptr_d     = rr_ptr_q;
        conflict_d   = conflict_q;
        drop_cnt_d   = drop_cnt_q;
        if (flush) begin
            slot_valid_d = '0;
            hist_valid_d = '0;
            conflict_d   = 1'b0;
        end else begin
            // Only empty slots capture, so a granted slot never reloads in its drain cycle.
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng2uca_valid[i] && !slot_valid_q[i]) begin
                    slot_valid_d[i] = 1'b1;
                    slot_lit_d[i]   = eng2uca_lit[i];
                end
            end
            if (grant) begin
                slot_valid_d[cand_idx] = 1'b0;
                rr_ptr_d = (cand_idx == PTR_W'(NUM_ENG - 1)) ? '0 : cand_idx + 1'b1;
                if (hit_same) begin
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end
                end else if (hit_opp) begin
                    conflict_d = 1'b1;
                end else begin
                    hist_lit_d   = {hist_lit_q[HIST_DEPTH-2:0], cand_lit};
                    hist_valid_d = {hist_valid_q[HIST_DEPTH-2:0], 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            hist_valid_q <= '0;
            rr_ptr_q     <= '0;
            conflict_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            hist_valid_q <= hist_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            conflict_q   <= conflict_d;
            drop_cnt_q   <= drop_cnt_d;
        end
        slot_lit_q <= slot_lit_d;
        hist_lit_q <= hist_lit_d;
    end
endmodule

// File: tb/tb_uc_arbiter.sv
// tb/tb_uc_arbiter.sv - scoreboard bench for uc_arbiter: directed scenarios then
// random traffic against a queue-based reference model.
module tb_uc_arbiter;
    localparam int N  = 4;
    localparam int LW = 9;
    localparam int CW = 16;
    localparam int HD = 8;

    logic                    clk = 1'b0;
    logic                    rst, flush, ucq_full;
    logic [N-1:0]            eng2uca_valid;
    logic [N-1:0][LW-1:0]    eng2uca_lit;
    logic [N-1:0]            uca2eng_ready;
    logic                    push;
    logic [LW-1:0]           uca2ucq;
    logic                    conflict;
    logic [CW-1:0]           drop_cnt;

    uc_arbiter #(.NUM_ENG(N), .UC_LENGTH(512), .HIST_DEPTH(HD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .eng2uca_valid(eng2uca_valid), .eng2uca_lit(eng2uca_lit),
        .uca2eng_ready(uca2eng_ready), .ucq_full(ucq_full),
        .push(push), .uca2ucq(uca2ucq), .conflict(conflict), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0]  rdy;
        logic          conf;
        logic [CW-1:0] drop;
        logic          psh;
        logic [LW-1:0] lit;
    } st_t;

    st_t           st_q[$];
    logic [LW-1:0] sb_q[$];
    st_t           mon_e;

    // Reference model state, expressed as plain arrays and a newest-first history queue.
    bit            m_sv[N];
    logic [LW-1:0] m_sl[N];
    logic [LW-1:0] m_hist[$];
    int            m_rr;
    bit            m_conf;
    int            m_drop;

    function automatic bit in_hist(input logic [LW-1:0] x);
        foreach (m_hist[j]) if (m_hist[j] == x) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_sv[i] = 1'b0;
        m_hist.delete();
        m_rr = 0; m_conf = 1'b0; m_drop = 0;
    endtask

    task automatic step(input logic r, input logic f, input logic full,
                        input logic [N-1:0] v, input logic [N-1:0][LW-1:0] l);
        st_t e;
        int g;
        bit dup, opp;
        logic [LW-1:0] lit_l;
        rst = r; flush = f; ucq_full = full; eng2uca_valid = v; eng2uca_lit = l;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && m_sv[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        for (int i = 0; i < N; i++) e.rdy[i] = !m_sv[i];
        e.conf = m_conf;
        e.drop = CW'(m_drop);
        lit_l  = (g >= 0) ? m_sl[g] : '0;
        e.lit  = lit_l;
        dup = in_hist(lit_l);
        opp = in_hist(lit_l ^ 9'h001);
        e.psh = (g >= 0) && !full && !m_conf && !f && !r && !dup && !opp;
        st_q.push_back(e);
        if (e.psh) sb_q.push_back(lit_l);
        if (r) begin
            model_reset();
        end else if (f) begin
            for (int i = 0; i < N; i++) m_sv[i] = 1'b0;
            m_hist.delete();
            m_conf = 1'b0;
        end else begin
            if (g >= 0 && !full && !m_conf) begin
                m_sv[g] = 1'b0;
                m_rr = (g + 1) % N;
                if (dup) begin
                    if (m_drop < 65535) m_drop++;
                end else if (opp) begin
                    m_conf = 1'b1;
                end else begin
                    m_hist.push_front(lit_l);
                    if (m_hist.size() > HD) void'(m_hist.pop_back());
                end
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && !e.rdy[i] == 1'b0 && i != g) begin
                    m_sv[i] = 1'b1;
                    m_sl[i] = l[i];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic offer(input int i, input logic [LW-1:0] x);
        logic [N-1:0][LW-1:0] l;
        logic [N-1:0] v;
        l = '0; v = '0;
        l[i] = x; v[i] = 1'b1;
        step(1'b0, 1'b0, 1'b0, v, l);
    endtask

    always @(negedge clk) begin
        if (st_q.size() > 0) begin
            mon_e = st_q.pop_front();
            chk("ready", 32'(uca2eng_ready), 32'(mon_e.rdy));
            chk("conflict", 32'(conflict), 32'(mon_e.conf));
            chk("drop_cnt", 32'(drop_cnt), 32'(mon_e.drop));
            chk("push", 32'(push), 32'(mon_e.psh));
            chk("uca2ucq", 32'(uca2ucq), 32'(mon_e.lit));
            if (push === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL push_lit: got push of %0h expected no push", uca2ucq);
                end else begin
                    chk("push_lit", 32'(uca2ucq), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [N-1:0][LW-1:0] l;
        logic [N-1:0] v;
        rst = 1'b1; flush = 1'b0; ucq_full = 1'b0; eng2uca_valid = '0; eng2uca_lit = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        idle(1);
        offer(0, 9'h014);
        idle(2);

        l = '0;
        l[0] = 9'h002; l[1] = 9'h004; l[2] = 9'h006; l[3] = 9'h008;
        step(1'b0, 1'b0, 1'b0, 4'b1111, l);
        idle(5);

        offer(0, 9'h020);
        idle(2);
        offer(1, 9'h020);
        idle(2);
        chk("drop_after_dup", 32'(drop_cnt), 32'd1);
        for (int k = 0; k < 9; k++) begin
            offer(2, LW'(9'h100 + 2 * k));
            idle(1);
        end
        offer(1, 9'h020);
        idle(2);
        chk("drop_after_evict", 32'(drop_cnt), 32'd1);

        offer(0, 9'h030);
        idle(2);
        offer(0, 9'h031);
        idle(2);
        chk("conflict_set", 32'(conflict), 32'd1);
        offer(2, 9'h040);
        idle(3);
        chk("held_slot_ready", 32'(uca2eng_ready[2]), 32'd0);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        chk("flush_conflict", 32'(conflict), 32'd0);
        chk("flush_ready", 32'(uca2eng_ready), 32'hF);
        offer(2, 9'h040);
        idle(2);

        l = '0;
        l[0] = 9'h050; l[1] = 9'h052;
        step(1'b0, 1'b0, 1'b1, 4'b0011, l);
        repeat (5) step(1'b0, 1'b0, 1'b1, '0, '0);
        chk("full_ready", 32'(uca2eng_ready), 32'hC);
        idle(3);

        offer(0, 9'h060);
        idle(2);
        offer(0, 9'h061);
        idle(2);
        l = '0;
        l[0] = 9'h070; l[1] = 9'h072; l[2] = 9'h074;
        step(1'b0, 1'b0, 1'b0, 4'b0111, l);
        idle(2);
        chk("pre_rst_ready", 32'(uca2eng_ready), 32'h8);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rst_ready", 32'(uca2eng_ready), 32'hF);
        chk("rst_conflict", 32'(conflict), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        idle(1);

        for (int c = 0; c < 3000; c++) begin
            v = N'($urandom);
            for (int i = 0; i < N; i++) l[i] = LW'($urandom_range(0, 31));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0), v, l);
        end
        idle(10);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
